// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency-meter measurement sequencer.
//   ctrl_state_e : sequencer states
//   ERR_*        : result error codes carried on res_err
package freq_meter_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        GATE      = 3'd2,
        WAIT_STOP = 3'd3,
        CAPTURE   = 3'd4,
        RESULT    = 3'd5
    } ctrl_state_e;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_START_TO = 2'd1;
    localparam logic [1:0] ERR_STOP_TO  = 2'd2;
    localparam logic [1:0] ERR_ZERO     = 2'd3;

endpackage

// File: rtl/freq_meas_ctrl_sync_edge.sv
// Multi-flop synchroniser with registered rising-edge detector.
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset
//   async_i : level from a foreign clock domain
//   level_o : synchronised level (STAGES cycles of latency)
//   rise_o  : one-cycle pulse, STAGES+1 cycles after the async rise
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;

    // Synchroniser chain, previous-level flop and registered edge pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{1'b0}};
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = rise_q;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer for the reciprocal-counting frequency meter.
// Opens the meter gate for gate_len clk_ref cycles, waits for the meter's
// start/stop acknowledgements, captures the counts and presents them on a
// valid/ready result port with an error code.
//   clk_ref/sys_rstn          : clock, async active-low reset
//   meas_start/cont_mode/abort: control
//   gate_cycles               : gate length, sampled when a start is accepted
//   start_ext/stop_ext        : meter flags (clk_meas domain)
//   ref_out/meas_out          : meter counts, stable while stop_ext is high
//   gate_en/busy              : gate request, sequencer activity
//   res_*                     : result port
module freq_meas_ctrl
    import freq_meter_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk_ref,
    input  logic             sys_rstn,
    input  logic             meas_start,
    input  logic             cont_mode,
    input  logic             abort,
    input  logic [CNT_W-1:0] gate_cycles,
    input  logic             start_ext,
    input  logic             stop_ext,
    input  logic [CNT_W-1:0] ref_out,
    input  logic [CNT_W-1:0] meas_out,
    output logic             gate_en,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_ref_cnt,
    output logic [CNT_W-1:0] res_meas_cnt,
    output logic [1:0]       res_err
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] gate_len_q, gate_len_d;
    logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0] res_ref_q, res_ref_d;
    logic [CNT_W-1:0] res_meas_q, res_meas_d;
    logic [1:0]       res_err_q, res_err_d;
    logic             gate_en_q, busy_q, res_valid_q;
    logic             start_p_s, stop_p_s, start_lvl_s, stop_lvl_s;
    logic             unused_s;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_start (
        .clk_i   (clk_ref),
        .rst_ni  (sys_rstn),
        .async_i (start_ext),
        .level_o (start_lvl_s),
        .rise_o  (start_p_s)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stop (
        .clk_i   (clk_ref),
        .rst_ni  (sys_rstn),
        .async_i (stop_ext),
        .level_o (stop_lvl_s),
        .rise_o  (stop_p_s)
    );

    // Synchronised levels are not needed for sequencing; only the edges are
    assign unused_s = start_lvl_s ^ stop_lvl_s;

    // Next-state, counter and result-register logic; abort overrides everything
    always_comb begin
        state_d    = state_q;
        gate_len_d = gate_len_q;
        gate_cnt_d = CNT_ZERO;
        tmo_cnt_d  = CNT_ZERO;
        res_ref_d  = res_ref_q;
        res_meas_d = res_meas_q;
        res_err_d  = res_err_q;
        if (abort) begin
            state_d    = IDLE;
            gate_len_d = CNT_ZERO;
            res_ref_d  = CNT_ZERO;
            res_meas_d = CNT_ZERO;
            res_err_d  = ERR_OK;
        end else begin
            case (state_q)
                IDLE: begin
                    if (meas_start) begin
                        state_d    = ARM;
                        gate_len_d = (gate_cycles == CNT_ZERO) ? CNT_ONE : gate_cycles;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ARM: begin
                    // start edge beats a timeout expiring in the same cycle
                    if (start_p_s) begin
                        state_d = GATE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_d    = RESULT;
                        res_ref_d  = CNT_ZERO;
                        res_meas_d = CNT_ZERO;
                        res_err_d  = ERR_START_TO;
                    end else begin
                        tmo_cnt_d = sat_inc(tmo_cnt_q);
                    end
                end
                GATE: begin
                    if (gate_cnt_q == (gate_len_q - CNT_ONE)) begin
                        state_d = WAIT_STOP;
                    end else begin
                        gate_cnt_d = sat_inc(gate_cnt_q);
                    end
                end
                WAIT_STOP: begin
                    if (stop_p_s) begin
                        state_d = CAPTURE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_d    = RESULT;
                        res_ref_d  = CNT_ZERO;
                        res_meas_d = CNT_ZERO;
                        res_err_d  = ERR_STOP_TO;
                    end else begin
                        tmo_cnt_d = sat_inc(tmo_cnt_q);
                    end
                end
                CAPTURE: begin
                    state_d = RESULT;
                    if (meas_out == CNT_ZERO) begin
                        res_ref_d  = CNT_ZERO;
                        res_meas_d = CNT_ZERO;
                        res_err_d  = ERR_ZERO;
                    end else begin
                        res_ref_d  = ref_out;
                        res_meas_d = meas_out;
                        res_err_d  = ERR_OK;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state_d = cont_mode ? ARM : IDLE;
                    end else begin
                        state_d = RESULT;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counters and result registers; outputs registered from next state
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q     <= IDLE;
            gate_len_q  <= CNT_ZERO;
            gate_cnt_q  <= CNT_ZERO;
            tmo_cnt_q   <= CNT_ZERO;
            res_ref_q   <= CNT_ZERO;
            res_meas_q  <= CNT_ZERO;
            res_err_q   <= ERR_OK;
            gate_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gate_len_q  <= gate_len_d;
            gate_cnt_q  <= gate_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            res_ref_q   <= res_ref_d;
            res_meas_q  <= res_meas_d;
            res_err_q   <= res_err_d;
            gate_en_q   <= (state_d == ARM) || (state_d == GATE);
            busy_q      <= (state_d != IDLE);
            res_valid_q <= (state_d == RESULT);
        end
    end

    assign gate_en      = gate_en_q;
    assign busy         = busy_q;
    assign res_valid    = res_valid_q;
    assign res_ref_cnt  = res_ref_q;
    assign res_meas_cnt = res_meas_q;
    assign res_err      = res_err_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl with a small behavioural meter model.
// clk_ref 10 MHz, clk_meas 1 MHz offset 25 ns from clk_ref edges.
module tb_freq_meas_ctrl;

    localparam int CNT_W = 32;

    logic             clk_ref, clk_meas, clk_meas_g, meas_en;
    logic             sys_rstn, meas_start, cont_mode, abort, res_ready;
    logic [CNT_W-1:0] gate_cycles;
    logic             start_ext, stop_ext;
    logic [CNT_W-1:0] ref_out, meas_out;
    logic             gate_en, busy, res_valid;
    logic [CNT_W-1:0] res_ref_cnt, res_meas_cnt;
    logic [1:0]       res_err;

    logic             m_clr, stop_block;
    int               m_state;
    int               checks, passes, fails;

    freq_meas_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(50), .SYNC_STAGES(2)) dut (
        .clk_ref      (clk_ref),
        .sys_rstn     (sys_rstn),
        .meas_start   (meas_start),
        .cont_mode    (cont_mode),
        .abort        (abort),
        .gate_cycles  (gate_cycles),
        .start_ext    (start_ext),
        .stop_ext     (stop_ext),
        .ref_out      (ref_out),
        .meas_out     (meas_out),
        .gate_en      (gate_en),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_ref_cnt  (res_ref_cnt),
        .res_meas_cnt (res_meas_cnt),
        .res_err      (res_err)
    );

    initial begin clk_ref = 1'b0; forever #50 clk_ref = ~clk_ref; end
    initial begin clk_meas = 1'b0; #25; forever #500 clk_meas = ~clk_meas; end
    assign clk_meas_g = clk_meas & meas_en;

    // Meter model: gate opens on a clk_meas edge seeing gate_en, closes on the
    // first clk_meas edge seeing gate_en low; re-arms when gate_en returns.
    always @(posedge clk_meas_g or posedge m_clr) begin
        if (m_clr) begin
            m_state <= 0; start_ext <= 1'b0; stop_ext <= 1'b0; meas_out <= 32'd0;
        end else begin
            case (m_state)
                0: if (gate_en) begin
                    start_ext <= 1'b1; stop_ext <= 1'b0; meas_out <= 32'd0; m_state <= 1;
                end
                1: begin
                    meas_out <= meas_out + 32'd1;
                    if (!gate_en && !stop_block) begin stop_ext <= 1'b1; m_state <= 2; end
                end
                2: if (gate_en) begin start_ext <= 1'b0; stop_ext <= 1'b0; m_state <= 0; end
                default: m_state <= 0;
            endcase
        end
    end

    // Reference count runs between gate open and gate close
    always @(posedge clk_ref) begin
        if (!start_ext) ref_out <= 32'd0;
        else if (!stop_ext) ref_out <= ref_out + 32'd1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        while (!res_valid && cyc < limit) begin
            @(negedge clk_ref);
            cyc++;
        end
    endtask

    task automatic handshake(input string tag, input logic exp_busy);
        res_ready = 1'b1;
        @(negedge clk_ref);
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, busy}, {31'd0, exp_busy});
    endtask

    task automatic pulse_mclr();
        m_clr = 1'b1; #1; m_clr = 1'b0;
    endtask

    task automatic run_single(input logic [31:0] g, input string tag);
        int cyc;
        int diff;
        logic extra;
        gate_cycles = g;
        meas_start  = 1'b1;
        @(negedge clk_ref);
        meas_start  = 1'b0;
        check({tag, "_gate_en_t1"}, {31'd0, gate_en}, 32'd1);
        check({tag, "_busy_t1"}, {31'd0, busy}, 32'd1);
        wait_valid(3000, cyc);
        check({tag, "_valid_seen"}, {31'd0, res_valid}, 32'd1);
        check({tag, "_err"}, {30'd0, res_err}, 32'd0);
        check({tag, "_ref_range"}, {31'd0, (res_ref_cnt >= 32'd1000 && res_ref_cnt <= 32'd1010)}, 32'd1);
        diff = int'(res_ref_cnt) - 10 * int'(res_meas_cnt);
        check({tag, "_ratio"}, {31'd0, (diff >= -1 && diff <= 1)}, 32'd1);
        handshake(tag, 1'b0);
        extra = 1'b0;
        repeat (20) begin
            @(negedge clk_ref);
            if (res_valid || busy) extra = 1'b1;
        end
        check({tag, "_single_result"}, {31'd0, extra}, 32'd0);
    endtask

    initial begin
        int cyc;
        int d;
        logic prev_gate, flag;
        logic [31:0] r0, m0;
        checks = 0; passes = 0; fails = 0;
        sys_rstn = 1'b0; meas_start = 1'b0; cont_mode = 1'b0; abort = 1'b0;
        res_ready = 1'b0; gate_cycles = 32'd0; meas_en = 1'b1; m_clr = 1'b1; stop_block = 1'b0;
        repeat (3) @(negedge clk_ref);
        check("rst_gate_en", {31'd0, gate_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_ref", res_ref_cnt, 32'd0);
        check("rst_meas", res_meas_cnt, 32'd0);
        check("rst_err", {30'd0, res_err}, 32'd0);
        sys_rstn = 1'b1; m_clr = 1'b0;
        @(negedge clk_ref);

        // Nominal single shot, gate 1000
        run_single(32'd1000, "s1");

        // Start timeout with clk_meas stopped
        meas_en = 1'b0;
        pulse_mclr();
        gate_cycles = 32'd100;
        meas_start = 1'b1;
        @(negedge clk_ref);
        meas_start = 1'b0;
        prev_gate = gate_en;
        cyc = 0;
        while (!res_valid && cyc < 60) begin
            prev_gate = gate_en;
            @(negedge clk_ref);
            cyc++;
        end
        check("s2_valid_seen", {31'd0, res_valid}, 32'd1);
        check("s2_within_52", {31'd0, (cyc <= 52)}, 32'd1);
        check("s2_gate_before", {31'd0, prev_gate}, 32'd1);
        check("s2_gate_falls", {31'd0, gate_en}, 32'd0);
        check("s2_err", {30'd0, res_err}, 32'd1);
        check("s2_ref_zero", res_ref_cnt, 32'd0);
        handshake("s2", 1'b0);

        // Stop timeout with stop_ext held low
        meas_en = 1'b1;
        pulse_mclr();
        stop_block = 1'b1;
        gate_cycles = 32'd100;
        meas_start = 1'b1;
        @(negedge clk_ref);
        meas_start = 1'b0;
        cyc = 0;
        while (gate_en && cyc < 300) begin @(negedge clk_ref); cyc++; end
        check("s3_gate_closed", {31'd0, gate_en}, 32'd0);
        flag = 1'b0;
        wait_valid(60, cyc);
        for (int i = 0; i < 1; i++) if (gate_en) flag = 1'b1;
        check("s3_valid_seen", {31'd0, res_valid}, 32'd1);
        check("s3_err", {30'd0, res_err}, 32'd2);
        check("s3_ref_zero", res_ref_cnt, 32'd0);
        check("s3_meas_zero", res_meas_cnt, 32'd0);
        check("s3_gate_low", {31'd0, flag}, 32'd0);
        handshake("s3", 1'b0);
        stop_block = 1'b0;
        pulse_mclr();

        // Continuous mode with a stalled consumer
        cont_mode = 1'b1;
        gate_cycles = 32'd200;
        meas_start = 1'b1;
        @(negedge clk_ref);
        meas_start = 1'b0;
        wait_valid(800, cyc);
        check("s4_r1_valid", {31'd0, res_valid}, 32'd1);
        check("s4_r1_err", {30'd0, res_err}, 32'd0);
        r0 = res_ref_cnt; m0 = res_meas_cnt;
        flag = 1'b0;
        repeat (20) begin
            @(negedge clk_ref);
            if (!res_valid || res_ref_cnt !== r0 || res_meas_cnt !== m0) flag = 1'b1;
        end
        check("s4_held_20", {31'd0, flag}, 32'd0);
        res_ready = 1'b1;
        @(negedge clk_ref);
        res_ready = 1'b0;
        check("s4_valid_drop", {31'd0, res_valid}, 32'd0);
        check("s4_gate_rearm", {31'd0, gate_en}, 32'd1);
        for (int k = 2; k <= 3; k++) begin
            wait_valid(800, cyc);
            check("s4_rn_valid", {31'd0, res_valid}, 32'd1);
            d = int'(res_ref_cnt) - int'(r0);
            check("s4_rn_ref_eq", {31'd0, (d >= -1 && d <= 1)}, 32'd1);
            d = int'(res_meas_cnt) - int'(m0);
            check("s4_rn_meas_eq", {31'd0, (d >= -1 && d <= 1)}, 32'd1);
            if (k == 3) cont_mode = 1'b0;
            handshake("s4_rn", (k == 3) ? 1'b0 : 1'b1);
        end
        pulse_mclr();

        // Abort in GATE, then start coinciding with a second abort
        gate_cycles = 32'd1000;
        meas_start = 1'b1;
        @(negedge clk_ref);
        meas_start = 1'b0;
        repeat (100) @(negedge clk_ref);
        check("s5_in_gate", {31'd0, gate_en}, 32'd1);
        abort = 1'b1;
        @(negedge clk_ref);
        abort = 1'b0;
        check("s5_busy", {31'd0, busy}, 32'd0);
        check("s5_gate", {31'd0, gate_en}, 32'd0);
        check("s5_valid", {31'd0, res_valid}, 32'd0);
        check("s5_res_cleared", res_ref_cnt, 32'd0);
        meas_start = 1'b1; abort = 1'b1;
        @(negedge clk_ref);
        meas_start = 1'b0; abort = 1'b0;
        check("s5_start_ignored", {31'd0, busy}, 32'd0);
        flag = 1'b0;
        repeat (30) begin
            @(negedge clk_ref);
            if (busy || res_valid || gate_en) flag = 1'b1;
        end
        check("s5_stays_idle", {31'd0, flag}, 32'd0);
        pulse_mclr();

        // Asynchronous reset in WAIT_STOP
        stop_block = 1'b1;
        gate_cycles = 32'd100;
        meas_start = 1'b1;
        @(negedge clk_ref);
        meas_start = 1'b0;
        cyc = 0;
        while (gate_en && cyc < 300) begin @(negedge clk_ref); cyc++; end
        repeat (5) @(negedge clk_ref);
        check("s6_waiting", {31'd0, busy}, 32'd1);
        #10;
        sys_rstn = 1'b0;
        #1;
        check("s6_rst_outputs", {26'd0, gate_en, busy, res_valid, res_err, (res_ref_cnt != 32'd0 || res_meas_cnt != 32'd0)}, 32'd0);
        m_clr = 1'b1; stop_block = 1'b0;
        @(negedge clk_ref);
        sys_rstn = 1'b1; m_clr = 1'b0;
        @(negedge clk_ref);
        run_single(32'd1000, "s6");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
